// File: rtl/enc_8x3_q.sv
// enc_8x3_q: queued 8-to-3 priority encoder with falling-edge capture.
// Pending requests are emitted highest-index first over valid/ready.
//
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  async active-low reset
//   req_n  in  8  active-low request lines (1->0 edge = event)
//   en_n   in  1  active-low capture enable
//   code   out 3  index of presented request
//   valid  out 1  code is valid
//   ready  in  1  consumer accepts on valid&ready
//   gs_n   out 1  low while anything is pending or presented
//   ovf    out 1  sticky duplicate-event flag (ENC_8X3_OVF_EN only)
//
// Build option: define ENC_8X3_OVF_EN to add the ovf port/register.

module enc_8x3_q (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_n,
   input  logic       en_n,
   output logic [2:0] code,
   output logic       valid,
   input  logic       ready,
   output logic       gs_n
`ifdef ENC_8X3_OVF_EN
   ,
   output logic       ovf
`endif
);

   typedef enum logic {
      S_IDLE,
      S_OUT
   } state_e;

   state_e     state_q;
   logic [7:0] prev_q;
   logic [7:0] pending_q;
   logic [7:0] pending_d;
   logic [2:0] code_q;
   logic       valid_q;

   logic [7:0] ev;
   logic [2:0] hi_idx;
   logic       take;
   logic [7:0] load_mask;

   // Highest set bit wins; later iterations override earlier ones.
   function automatic logic [2:0] hi_idx_f(input logic [7:0] v);
      hi_idx_f = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) hi_idx_f = 3'(i);
      end
   endfunction

   always_comb begin
      ev        = en_n ? 8'h00 : (prev_q & ~req_n);
      hi_idx    = hi_idx_f(pending_q);
      // Load from registered pending only; ready is ignored in IDLE.
      take      = (pending_q != 8'h00) &&
                  ((state_q == S_IDLE) || ready);
      load_mask = take ? (8'd1 << hi_idx) : 8'h00;
      // A fresh event on a bit being loaded keeps it pending.
      pending_d = (pending_q & ~load_mask) | ev;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         prev_q    <= 8'hFF;
         pending_q <= 8'h00;
         code_q    <= 3'd0;
         valid_q   <= 1'b0;
      end else begin
         prev_q    <= req_n;
         pending_q <= pending_d;
         unique case (state_q)
            S_IDLE: begin
               if (take) begin
                  code_q  <= hi_idx;
                  valid_q <= 1'b1;
                  state_q <= S_OUT;
               end
            end
            S_OUT: begin
               if (ready) begin
                  if (take) begin
                     code_q <= hi_idx;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign code  = code_q;
   assign valid = valid_q;
   assign gs_n  = ~((|pending_q) | valid_q);

`ifdef ENC_8X3_OVF_EN
   logic ovf_q;
   logic ovf_set;

   // Duplicate event on a bit still waiting (not leaving this cycle).
   assign ovf_set = |(ev & pending_q & ~load_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (ovf_set) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_enc_8x3_q.sv
// tb_enc_8x3_q: scoreboard bench for enc_8x3_q.
// Expected codes are queued at stimulus time, popped on handshake.

module tb_enc_8x3_q;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_n;
   logic       en_n;
   logic [2:0] code;
   logic       valid;
   logic       ready;
   logic       gs_n;
`ifdef ENC_8X3_OVF_EN
   logic       ovf;
`endif

   int checks;
   int failures;
   int exp_q[$];

   enc_8x3_q dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req_n (req_n),
      .en_n  (en_n),
      .code  (code),
      .valid (valid),
      .ready (ready),
      .gs_n  (gs_n)
`ifdef ENC_8X3_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Handshake monitor: valid/ready are stable at the falling edge.
   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", 32'(exp_q.size()), 32'd1);
         end else begin
            check("sb_code", 32'(code), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      req_n    = 8'hFF;
      en_n     = 1'b0;
      ready    = 1'b0;
      tick(2);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_gs_n", 32'(gs_n), 32'd1);
      check("rst_code", 32'(code), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single request, ready high.
      ready = 1'b1;
      req_n = 8'hF7;
      exp_q.push_back(3);
      tick();
      check("single_lat_valid", 32'(valid), 32'd0);
      check("single_lat_gs", 32'(gs_n), 32'd0);
      tick();
      check("single_valid", 32'(valid), 32'd1);
      check("single_code", 32'(code), 32'd3);
      tick();
      check("single_done", 32'(valid), 32'd0);
      req_n = 8'hFF;
      tick(2);

      // Priority, back-to-back.
      req_n = 8'h5A;
      exp_q.push_back(7);
      exp_q.push_back(5);
      exp_q.push_back(2);
      exp_q.push_back(0);
      tick(2);
      check("prio_c7", 32'(code), 32'd7);
      tick();
      check("prio_c5", 32'(code), 32'd5);
      tick();
      check("prio_c2", 32'(code), 32'd2);
      tick();
      check("prio_c0", 32'(code), 32'd0);
      check("prio_v0", 32'(valid), 32'd1);
      tick();
      check("prio_end_valid", 32'(valid), 32'd0);
      check("prio_end_gs", 32'(gs_n), 32'd1);
      req_n = 8'hFF;
      tick(2);

      // Backpressure.
      ready = 1'b0;
      req_n = 8'hBD;
      exp_q.push_back(6);
      exp_q.push_back(1);
      tick(2);
      for (int i = 0; i < 5; i++) begin
         check("bp_code", 32'(code), 32'd6);
         check("bp_valid", 32'(valid), 32'd1);
         tick();
      end
      ready = 1'b1;
      tick();
      check("bp_next", 32'(code), 32'd1);
      tick();
      check("bp_done", 32'(valid), 32'd0);
      req_n = 8'hFF;
      tick(2);

      // Edge during disable is lost; level is not an event.
      en_n  = 1'b1;
      req_n = 8'hEF;
      tick(2);
      en_n = 1'b0;
      tick(4);
      check("en_valid", 32'(valid), 32'd0);
      check("en_gs", 32'(gs_n), 32'd1);
      req_n = 8'hFF;
      tick();
      req_n = 8'hEF;
      exp_q.push_back(4);
      tick(2);
      check("en_code4", 32'(code), 32'd4);
      check("en_valid4", 32'(valid), 32'd1);
      tick();
      req_n = 8'hFF;
      tick(2);

      // Duplicate event while pending: one code 5 only.
      ready = 1'b0;
      req_n = 8'hF7;
      exp_q.push_back(3);
      tick(2);
      check("dup_code3", 32'(code), 32'd3);
      req_n = 8'hD7;
      exp_q.push_back(5);
      tick();
      req_n = 8'hF7;
      tick();
`ifdef ENC_8X3_OVF_EN
      check("ovf_before", 32'(ovf), 32'd0);
`endif
      req_n = 8'hD7;
      tick();
`ifdef ENC_8X3_OVF_EN
      check("ovf_set", 32'(ovf), 32'd1);
`endif
      req_n = 8'hFF;
      tick(2);
      ready = 1'b1;
      tick(4);
      check("dup_done", 32'(valid), 32'd0);
`ifdef ENC_8X3_OVF_EN
      check("ovf_sticky", 32'(ovf), 32'd1);
`endif

      // Reset mid-stream with pending=0x24 and code 7 presented.
      ready = 1'b0;
      req_n = 8'h7F;
      tick(2);
      req_n = 8'h5B;
      tick(2);
      check("mid_valid", 32'(valid), 32'd1);
      check("mid_code", 32'(code), 32'd7);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mrst_valid", 32'(valid), 32'd0);
      check("mrst_gs", 32'(gs_n), 32'd1);
      check("mrst_code", 32'(code), 32'd0);
`ifdef ENC_8X3_OVF_EN
      check("mrst_ovf", 32'(ovf), 32'd0);
`endif
      req_n = 8'hFF;
      tick(2);
      rst_n = 1'b1;
      ready = 1'b1;
      tick(5);
      check("post_valid", 32'(valid), 32'd0);
      check("post_gs", 32'(gs_n), 32'd1);
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
